// File: rtl/serial_pkg.sv
// serial_pkg: shared constants and state type for the serial receiver.
package serial_pkg;
    localparam int DATA_W_DEF = 8;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT = 1'b1;
    typedef enum logic [1:0] {IDLE, DATA, STOP} rx_state_t;
endpackage

// File: rtl/serial_receiver_if.sv
// serial_receiver_if: serial line in, framed parallel word and status out.
interface serial_receiver_if
    import serial_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic              ser_in;
    logic              shift_en;
    logic [0:DATA_W-1] Par_out;
    logic              data_valid;
    logic              frame_err;
    logic              busy;
    modport master(output ser_in, shift_en, input Par_out, data_valid, frame_err, busy);
    modport slave(input ser_in, shift_en, output Par_out, data_valid, frame_err, busy);
endinterface

// File: rtl/rx_shift_reg.sv
// rx_shift_reg: indexed bit-capture register; index 0 is the first bit received.
module rx_shift_reg
    import serial_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    localparam int CNT_W = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [CNT_W-1:0]  idx_i,
    input  logic              bit_i,
    output logic [0:DATA_W-1] q_o
);
    always_ff @(posedge clk) begin
        if (rst) q_o <= '0;
        else if (we_i) q_o[idx_i] <= bit_i;
    end
endmodule

// File: rtl/serial_receiver.sv
// serial_receiver: start/data/stop frame receiver sampling ser_in on shift_en strobes.
module serial_receiver
    import serial_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input logic              Clk,
    input logic              reset,
    serial_receiver_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);
    rx_state_t         state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [0:DATA_W-1] shreg;
    logic [0:DATA_W-1] par_q;
    logic              valid_q, err_q, busy_q;
    rx_shift_reg #(.DATA_W(DATA_W)) u_shreg (
        .clk  (Clk),
        .rst  (reset),
        .we_i (bus.shift_en && state_q == DATA),
        .idx_i(cnt_q),
        .bit_i(bus.ser_in),
        .q_o  (shreg)
    );
    // busy tracks the state being entered, so it rises with the start sample and falls with the stop sample
    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            par_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            if (bus.shift_en) begin
                case (state_q)
                    IDLE: if (bus.ser_in == START_BIT) begin
                        state_q <= DATA;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                    DATA: begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == LAST) state_q <= STOP;
                    end
                    default: begin
                        if (bus.ser_in == STOP_BIT) begin
                            par_q   <= shreg;
                            valid_q <= 1'b1;
                        end else err_q <= 1'b1;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end
    assign bus.Par_out    = par_q;
    assign bus.data_valid = valid_q;
    assign bus.frame_err  = err_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_serial_receiver.sv
// tb_serial_receiver: directed frames with a scoreboard queue checked by a pulse monitor.
module tb_serial_receiver;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    typedef struct packed {
        logic       err;
        logic [0:7] data;
    } exp_t;
    exp_t       exp_q[$];
    logic [0:7] last_good = '0;
    serial_receiver_if #(.DATA_W(8)) bus ();
    serial_receiver #(.DATA_W(8)) dut (.Clk(clk), .reset(rst), .bus(bus));
    always #5 clk = ~clk;
    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction
    always @(negedge clk) begin
        if (bus.data_valid || bus.frame_err) begin
            exp_t e;
            checks++;
            if (bus.data_valid && bus.frame_err) begin
                errors++;
                $display("FAIL excl: data_valid and frame_err both high");
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pulse: unexpected dv=%0b fe=%0b par=%b", bus.data_valid, bus.frame_err, bus.Par_out);
            end else begin
                e = exp_q.pop_front();
                if (bus.frame_err !== e.err || bus.Par_out !== e.data) begin
                    errors++;
                    $display("FAIL pulse: got fe=%0b par=%b expected fe=%0b par=%b", bus.frame_err, bus.Par_out, e.err, e.data);
                end
            end
        end
    end
    task automatic send_bit(input logic b, input int gap, input logic chkb, input logic eb);
        bus.ser_in   = b;
        bus.shift_en = 1'b1;
        @(posedge clk);
        #1;
        bus.shift_en = 1'b0;
        if (chkb) chk("busy", 32'(bus.busy), 32'(eb));
        repeat (gap) begin
            @(posedge clk);
            #1;
            if (chkb) chk("busy_gap", 32'(bus.busy), 32'(eb));
        end
    endtask
    task automatic send_frame(input logic [0:7] d, input logic stop, input int gap);
        send_bit(1'b0, gap, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) send_bit(d[i], gap, 1'b1, 1'b1);
        if (stop) begin
            exp_q.push_back('{err: 1'b0, data: d});
            last_good = d;
        end else exp_q.push_back('{err: 1'b1, data: last_good});
        send_bit(stop, gap, 1'b1, 1'b0);
    endtask
    initial begin
        bus.ser_in   = 1'b1;
        bus.shift_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_dv", 32'(bus.data_valid), 0);
        chk("rst_fe", 32'(bus.frame_err), 0);
        chk("rst_par", 32'(bus.Par_out), 0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) send_bit(1'b1, 0, 1'b1, 1'b0);
        chk("idle_par", 32'(bus.Par_out), 0);
        send_frame(8'b10101011, 1'b1, 0);
        send_bit(1'b1, 1, 1'b0, 1'b0);
        chk("par_028", 32'(bus.Par_out), 32'(8'b10101011));
        send_frame(8'b10101011, 1'b1, 2);
        chk("par_029", 32'(bus.Par_out), 32'(8'b10101011));
        send_frame(8'b11011001, 1'b0, 0);
        send_bit(1'b1, 1, 1'b0, 1'b0);
        chk("par_030", 32'(bus.Par_out), 32'(8'b10101011));
        send_bit(1'b0, 0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 0, 1'b1, 1'b1);
        rst = 1'b1;
        bus.ser_in   = 1'b0;
        bus.shift_en = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.shift_en = 1'b0;
        last_good = '0;
        chk("abort_busy", 32'(bus.busy), 0);
        chk("abort_par", 32'(bus.Par_out), 0);
        send_frame(8'b11011001, 1'b1, 0);
        send_bit(1'b1, 1, 1'b0, 1'b0);
        chk("par_031", 32'(bus.Par_out), 32'(8'b11011001));
        send_frame(8'b10101011, 1'b1, 0);
        send_frame(8'b11011001, 1'b1, 0);
        send_bit(1'b1, 3, 1'b0, 1'b0);
        chk("par_033", 32'(bus.Par_out), 32'(8'b11011001));
        chk("sb_empty", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
